// File: rtl/timer_periph_pkg.sv
// rtl/timer_periph_pkg.sv - shared constants for the memory-mapped timer/compare peripheral
package timer_periph_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t OFF_CTRL  = 8'd0;
    localparam data_t OFF_PRESC = 8'd1;
    localparam data_t OFF_CMP   = 8'd2;
    localparam data_t OFF_CNT   = 8'd3;
    localparam data_t OFF_STAT  = 8'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - prescale counter producing one tick every presc+1 enabled cycles
module timer_prescaler
    import timer_periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  data_t       presc,
    input  logic        clear,
    output logic        tick
);

    data_t pcnt_q;
    data_t pcnt_d;

    assign tick = en & (pcnt_q == presc);

    always_comb begin
        pcnt_d = '0;
        if (!clear && en && !tick) begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timer_periph.sv
// rtl/timer_periph.sv - data-bus timer with compare flag, interrupt, one-shot/auto-reload modes
module timer_periph
    import timer_periph_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_Address,
    input  logic [7:0] i_DataIn,
    input  logic       i_WR,
    output logic [7:0] o_DataOut,
    output logic       o_Hit,
    output logic       o_IRQ
);

    logic [2:0] ctrl_q, ctrl_d;
    data_t      presc_q, presc_d;
    data_t      cmp_q, cmp_d;
    data_t      cnt_q, cnt_d;
    logic       flag_q, flag_d;

    data_t      off;
    logic       wr;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_stat;
    logic       tick;
    logic       match;
    logic       psc_clear;

    assign o_Hit    = (i_Address >= BASE_ADDR) && (i_Address <= BASE_ADDR + 8'd4);
    assign off      = i_Address - BASE_ADDR;
    assign wr       = o_Hit & i_WR;
    assign wr_ctrl  = wr && (off == OFF_CTRL);
    assign wr_presc = wr && (off == OFF_PRESC);
    assign wr_cmp   = wr && (off == OFF_CMP);
    assign wr_cnt   = wr && (off == OFF_CNT);
    assign wr_stat  = wr && (off == OFF_STAT);

    assign psc_clear = (wr_ctrl & ~i_DataIn[CTRL_EN]) | wr_presc;

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q[CTRL_EN]),
        .presc (presc_q),
        .clear (psc_clear),
        .tick  (tick)
    );

    // A CPU write to COUNT suppresses match evaluation for that edge entirely.
    assign match = tick & ~wr_cnt & (cnt_q == cmp_q);

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = wr_presc ? i_DataIn : presc_q;
        cmp_d   = wr_cmp ? i_DataIn : cmp_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;

        if (match) begin
            if (ctrl_q[CTRL_AUTO]) begin
                cnt_d = '0;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (wr_cnt) begin
            cnt_d = i_DataIn;
        end
        if (wr_ctrl) begin
            ctrl_d = i_DataIn[2:0];
        end
        if (wr_stat && i_DataIn[0]) begin
            flag_d = 1'b0;
        end
        if (match) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= 8'hFF;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    assign o_IRQ = flag_q & ctrl_q[CTRL_IE];

    always_comb begin
        o_DataOut = '0;
        if (o_Hit) begin
            case (off)
                OFF_CTRL:  o_DataOut = {5'b0, ctrl_q};
                OFF_PRESC: o_DataOut = presc_q;
                OFF_CMP:   o_DataOut = cmp_q;
                OFF_CNT:   o_DataOut = cnt_q;
                OFF_STAT:  o_DataOut = {7'b0, flag_q};
                default:   o_DataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_periph.sv
// tb/tb_timer_periph.sv - self-checking bench for timer_periph with a behavioural model
module tb_timer_periph;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk;
    logic       reset;
    logic [7:0] i_Address;
    logic [7:0] i_DataIn;
    logic       i_WR;
    logic [7:0] o_DataOut;
    logic       o_Hit;
    logic       o_IRQ;

    int tests = 0;
    int fails = 0;

    timer_periph #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_Address (i_Address),
        .i_DataIn  (i_DataIn),
        .i_WR      (i_WR),
        .o_DataOut (o_DataOut),
        .o_Hit     (o_Hit),
        .o_IRQ     (o_IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain integers stepped once per rising edge.
    bit m_valid = 0;
    bit m_en, m_auto, m_ie, m_flag;
    int m_presc, m_cmp, m_cnt, m_pcnt;

    function automatic bit in_window(input int a);
        return (a >= BASE) && (a <= BASE + 4);
    endfunction

    function automatic int model_rd(input int a);
        if (!in_window(a)) return 0;
        case (a - BASE)
            0: return m_en + 2 * m_auto + 4 * m_ie;
            1: return m_presc;
            2: return m_cmp;
            3: return m_cnt;
            default: return m_flag;
        endcase
    endfunction

    task automatic model_step(input int a, input int d, input bit w, input bit r);
        bit tick, do_wr, hit_match;
        int off, n_pcnt;
        if (!r) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_flag = 0;
            m_presc = 0; m_cmp = 255; m_cnt = 0; m_pcnt = 0;
            m_valid = 1;
            return;
        end
        do_wr = in_window(a) && w;
        off = a - BASE;
        tick = m_en && (m_pcnt == m_presc);
        n_pcnt = m_en ? (tick ? 0 : m_pcnt + 1) : 0;
        hit_match = tick && !(do_wr && off == 3) && (m_cnt == m_cmp);
        if (tick && !(do_wr && off == 3)) begin
            if (m_cnt == m_cmp) begin
                if (m_auto) m_cnt = 0;
                else m_en = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        if (do_wr) begin
            case (off)
                0: begin
                    m_en = d[0]; m_auto = d[1]; m_ie = d[2];
                    if (!d[0]) n_pcnt = 0;
                end
                1: begin m_presc = d; n_pcnt = 0; end
                2: m_cmp = d;
                3: m_cnt = d;
                default: if (d[0] && !hit_match) m_flag = 0;
            endcase
        end
        if (hit_match) m_flag = 1;
        m_pcnt = n_pcnt;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_hit", o_Hit, in_window(i_Address));
            chk("cyc_data", o_DataOut, model_rd(i_Address));
            chk("cyc_irq", o_IRQ, m_flag & m_ie);
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w, input logic r);
        i_Address = a; i_DataIn = d; i_WR = w; reset = r;
        @(posedge clk);
        model_step(a, d, w, r);
        #1;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        drive(BASE + off[7:0], d, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic rd(input int off, input int exp, input string nm);
        i_Address = BASE + off[7:0]; i_WR = 1'b0;
        #1;
        chk({nm, "_hit"}, o_Hit, 1);
        chk(nm, o_DataOut, exp);
    endtask

    initial begin
        reset = 1'b0; i_Address = 8'h00; i_DataIn = 8'h00; i_WR = 1'b0;

        // Reset and decode
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rd(0, 8'h00, "rst_ctrl");
        rd(1, 8'h00, "rst_presc");
        rd(2, 8'hFF, "rst_cmp");
        rd(3, 8'h00, "rst_cnt");
        rd(4, 8'h00, "rst_stat");
        chk("rst_irq", o_IRQ, 0);
        i_Address = BASE - 8'd1; #1;
        chk("below_hit", o_Hit, 0);
        chk("below_data", o_DataOut, 0);
        i_Address = BASE + 8'd5; #1;
        chk("above_hit", o_Hit, 0);
        chk("above_data", o_DataOut, 0);

        // Auto-reload, PRESC=0
        wr(2, 8'h03);
        wr(0, 8'h07);
        idle(1); rd(3, 1, "ar_cnt1");
        idle(1); rd(3, 2, "ar_cnt2");
        idle(1); rd(3, 3, "ar_cnt3");
        idle(1); rd(3, 0, "ar_cnt_reload"); rd(4, 1, "ar_flag");
        chk("ar_irq", o_IRQ, 1);
        idle(4); rd(4, 1, "ar_flag_e8");
        wr(4, 8'h01);
        rd(4, 0, "ar_flag_clr");
        chk("ar_irq_clr", o_IRQ, 0);
        wr(0, 8'h00);

        // Prescaler, PRESC=2
        wr(3, 8'h00);
        wr(1, 8'h02);
        wr(2, 8'hFF);
        wr(0, 8'h01);
        idle(2); rd(3, 0, "psc_e2");
        idle(1); rd(3, 1, "psc_e3");
        idle(3); rd(3, 2, "psc_e6");
        idle(1);
        wr(1, 8'h02);
        idle(2); rd(3, 2, "psc_rewrite_hold");
        idle(1); rd(3, 3, "psc_rewrite_inc");
        wr(0, 8'h00);

        // One-shot
        wr(1, 8'h00);
        wr(3, 8'h00);
        wr(2, 8'h02);
        wr(0, 8'h01);
        idle(3);
        rd(4, 1, "os_flag");
        rd(3, 2, "os_cnt");
        rd(0, 0, "os_ctrl");
        idle(10);
        rd(3, 2, "os_cnt_held");
        chk("os_irq", o_IRQ, 0);
        wr(4, 8'h01);

        // Collisions
        wr(2, 8'hFF);
        wr(3, 8'h00);
        wr(0, 8'h01);
        idle(1);
        wr(3, 8'h10);
        rd(3, 8'h10, "col_cnt_write");
        idle(1); rd(3, 8'h11, "col_cnt_next");
        wr(2, 8'h13);
        idle(1); rd(3, 8'h13, "col_pre_match");
        wr(4, 8'h01);
        rd(4, 1, "col_stat_vs_match");
        rd(3, 8'h13, "col_oneshot_hold");
        wr(4, 8'h01);
        rd(4, 0, "col_stat_clear");
        wr(2, 8'h05);
        wr(3, 8'hFF);
        wr(0, 8'h01);
        idle(1);
        rd(3, 8'h00, "wrap_cnt");
        rd(4, 0, "wrap_flag");
        wr(0, 8'h00);

        // Reset mid-operation
        wr(2, 8'h03);
        wr(3, 8'h00);
        wr(0, 8'h07);
        idle(4);
        rd(4, 1, "mr_flag");
        wr(3, 8'h06);
        idle(1);
        rd(3, 7, "mr_cnt7");
        chk("mr_irq_pre", o_IRQ, 1);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rd(0, 8'h00, "mr_ctrl");
        rd(1, 8'h00, "mr_presc");
        rd(2, 8'hFF, "mr_cmp");
        rd(3, 8'h00, "mr_cnt");
        rd(4, 8'h00, "mr_stat");
        chk("mr_irq", o_IRQ, 0);
        idle(1);
        rd(3, 8'h00, "mr_no_tick");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_periph.md
Name: timer_periph

Overview:
- Memory-mapped 8-bit timer/compare peripheral that acts as a responder on the microcontroller's data bus (address, write data, W_R, read data).
- Sits beside the data RAM in the Harvard top level. The top level uses o_Hit to steer read data: this block's o_DataOut is selected over the RAM's when o_Hit is 1.
- Provides a prescaled up-counter, a compare match flag with an optional interrupt, and one-shot or auto-reload mode.

Parameters:
- BASE_ADDR, 8'hF0, first data-bus address of the 5-register window (BASE_ADDR..BASE_ADDR+4). Must be ≤ 8'hFB.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-low: reset==0 at a rising clk edge resets all state.
- i_Address  input  8  data-bus address from the micro.
- i_DataIn  input  8  write data from the micro.
- i_WR  input  1  1 = write at the next rising clk edge; 0 = read.
- o_DataOut  output  8  read data, combinational from address; 8'h00 when not hit.
- o_Hit  output  1  combinational; 1 when i_Address is in [BASE_ADDR, BASE_ADDR+4].
- o_IRQ  output  1  FLAG & IE, driven from registers only (no combinational path from inputs).

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; bits 7:3 read as 0.
  - 1 PRESC: 8-bit prescaler divisor.
  - 2 COMPARE: 8-bit compare value.
  - 3 COUNT: 8-bit counter, read/write.
  - 4 STATUS: bit0 FLAG, write-1-to-clear; other bits read 0.
- Reset values: CTRL=0, PRESC=0, COMPARE=8'hFF, COUNT=0, FLAG=0, internal prescale counter pcnt=0. Resulting outputs: o_IRQ=0; o_DataOut per address decode.
- Reads: zero-latency combinational mux. Reads have no side effects.
- Writes: take effect at the rising edge where o_Hit & i_WR. Writes outside the window are ignored.
- tick = EN & (pcnt == PRESC).
  - Each edge with EN=1: pcnt <= tick ? 0 : pcnt+1.
  - EN=0: pcnt holds 0.
  - PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles.
- On tick:
  - If COUNT == COMPARE (match): FLAG <= 1. Then if AUTO=1, COUNT <= 0; if AUTO=0, COUNT holds and EN <= 0 (one-shot stop).
  - Otherwise: COUNT <= COUNT+1, mod 256. 255 wraps to 0 with no flag unless it matches COMPARE.
- EN written 1 at edge E0: first possible tick at edge E1.
- Writing CTRL with EN=0, or any write to PRESC: pcnt <= 0 at that edge.
- Simultaneous events at the same edge:
  - CPU write to COUNT beats the tick update; the written value is loaded and no match is evaluated that edge.
  - CPU write to CTRL beats the one-shot EN clear.
  - STATUS write-1 plus a match-set: set wins, FLAG stays 1.
  - STATUS write-0: no effect.
- reset asserted mid-count: all state returns to reset values at that edge. No tick occurs on that edge.

Decomposition:
- Shared package holds:
  - register offset constants: OFF_CTRL=0, OFF_PRESC=1, OFF_CMP=2, OFF_CNT=3, OFF_STAT=4;
  - CTRL bit indices: EN=0, AUTO=1, IE=2;
  - the data-bus width constant (8).
- One natural sub-module, timer_prescaler: holds pcnt and produces tick, with inputs EN, PRESC and a clear. The register file and counter logic stay in timer_periph.

Test Plan:
- Reset and decode: hold reset=0 for 2 cycles, then read offsets 0..4 → 00,00,FF,00,00. Read BASE_ADDR-1 and BASE_ADDR+5 → o_Hit=0, o_DataOut=00.
- Auto-reload, PRESC=0: write COMPARE=3, then CTRL=8'h07 at edge E0.
  - COUNT reads 1,2,3 after E1..E3.
  - At E4: FLAG=1, o_IRQ=1, COUNT=0.
  - At E8: FLAG still 1.
  - Write STATUS=01 → FLAG=0, o_IRQ=0.
- Prescaler, PRESC=2: COMPARE=FF, CTRL=01 → COUNT increments every 3 cycles (1 after E3, 2 after E6). Rewrite PRESC=2 mid-period → next increment exactly 3 cycles after that write.
- One-shot: COMPARE=2, CTRL=01 (AUTO=0) → at E3 FLAG=1, COUNT stays 2, CTRL reads 00. COUNT remains 2 for 10 further cycles; o_IRQ stays 0 because IE=0.
- Collisions:
  - Write COUNT=8'h10 on the same edge a tick would increment → COUNT=10.
  - Write STATUS=01 on the same edge as a match → FLAG=1.
  - Wrap: COMPARE=05, COUNT=FF → next tick gives COUNT=00 with no flag.
- Reset mid-operation: running at COUNT=7 with FLAG=1, apply reset=0 for one edge → all registers at reset values and o_IRQ=0. Next edge after release: no tick.
